// File: rtl/cache_mem_arbiter.sv
// Serializes icache (read) and dcache (read/write) word requests onto one RAM port.
// Optional perf counters: define CACHE_MEM_ARBITER_PERF_EN.
module cache_mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready
`ifdef CACHE_MEM_ARBITER_PERF_EN
  ,
  output logic [31:0] dcount,
  output logic [31:0] icount,
  output logic [31:0] stallcount
`endif
);

  typedef enum logic [1:0] {IDLE, D_ACC, I_ACC} state_t;

  state_t     r_state, w_next;
  logic [3:0] r_starve;
  logic       w_dreq, w_force, w_d_done, w_i_done;

  assign w_dreq   = dREN | dWEN;
  assign w_force  = iREN && (r_starve == 4'(STARVE_MAX));
  assign w_d_done = ~dwait;
  assign w_i_done = ~iwait;

  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Strobes and completion are driven from the live request so an abort
  // drops the RAM access in the same cycle.
  always_comb begin
    w_next   = r_state;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    if (!RST) begin
      case (r_state)
        IDLE: begin
          if (w_dreq && !w_force) w_next = D_ACC;
          else if (iREN)          w_next = I_ACC;
        end
        D_ACC: begin
          if (!w_dreq) begin
            w_next = IDLE;
          end else begin
            ramaddr = daddr;
            if (dWEN) begin
              ramWEN   = 1'b1;
              ramstore = dstore;
            end else begin
              ramREN = 1'b1;
            end
            if (ramready) begin
              dwait  = 1'b0;
              dload  = dWEN ? 32'h0 : ramload;
              w_next = IDLE;
            end
          end
        end
        I_ACC: begin
          if (!iREN) begin
            w_next = IDLE;
          end else begin
            ramREN  = 1'b1;
            ramaddr = iaddr;
            if (ramready) begin
              iwait  = 1'b0;
              iload  = ramload;
              w_next = IDLE;
            end
          end
        end
        default: w_next = IDLE;
      endcase
    end
  end

  // Counts dcache wins over a waiting icache; at STARVE_MAX the icache is forced in.
  always_ff @(posedge CLK) begin
    if (RST)
      r_starve <= '0;
    else if (w_i_done || (r_state == IDLE && !iREN))
      r_starve <= '0;
    else if (w_d_done && iREN && r_starve != 4'(STARVE_MAX))
      r_starve <= r_starve + 4'd1;
  end

`ifdef CACHE_MEM_ARBITER_PERF_EN
  logic [31:0] r_dcount, r_icount, r_stallcount;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_dcount     <= '0;
      r_icount     <= '0;
      r_stallcount <= '0;
    end else begin
      if (w_d_done) r_dcount <= r_dcount + 32'd1;
      if (w_i_done) r_icount <= r_icount + 32'd1;
      if (r_state != IDLE && !ramready) r_stallcount <= r_stallcount + 32'd1;
    end
  end

  assign dcount     = r_dcount;
  assign icount     = r_icount;
  assign stallcount = r_stallcount;
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios plus randomized cache agents
// checked against a transaction-level memory/arbitration model.
module tb_cache_mem_arbiter;
  localparam int unsigned SMAX = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN, ramready;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;
`ifdef CACHE_MEM_ARBITER_PERF_EN
  logic [31:0] dcount, icount, stallcount;
`endif

  cache_mem_arbiter #(.STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready)
`ifdef CACHE_MEM_ARBITER_PERF_EN
    , .dcount(dcount), .icount(icount), .stallcount(stallcount)
`endif
  );

  always #5 CLK = ~CLK;

  int n_vec = 0, n_err = 0;
  int stall = 0, rcnt = 0;
  bit rand_stall = 0;
  logic [31:0] ram  [logic [31:0]];
  logic [31:0] gold [logic [31:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a * 32'h9E3779B1 + 32'h1;
  endfunction
  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_val(a);
  endfunction
  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    return gold.exists(a) ? gold[a] : init_val(a);
  endfunction

  // RAM responder: ready after 'stall' cycles of a held strobe.
  task automatic settle();
    #1;
    if (ramREN || ramWEN) begin
      if (rcnt == 0 && rand_stall) stall = $urandom_range(0, 3);
      ramready = (rcnt >= stall);
      ramload  = ramREN ? ram_rd(ramaddr) : $urandom;
    end else begin
      ramready = 1'b0;
      ramload  = $urandom;
    end
    #1;
  endtask

  task automatic tick();
    if (ramWEN && ramready) ram[ramaddr] = ramstore;
    if (ramready || !(ramREN || ramWEN)) rcnt = 0;
    else rcnt++;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // random-phase agent state
  bit          d_busy, d_wr, i_busy;
  int          d_age, i_age, streak;

  initial begin
    RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramready = 0; ramload = 0;
    @(negedge CLK);
    repeat (2) begin
      settle();
      chk("rst_iwait", 32'(iwait), 1);
      chk("rst_dwait", 32'(dwait), 1);
      chk("rst_strobes", {30'b0, ramREN, ramWEN}, 0);
      chk("rst_ramaddr", ramaddr, 0);
      chk("rst_ramstore", ramstore, 0);
      chk("rst_loads", iload | dload, 0);
      tick();
    end
    RST = 1'b0;

    // T1: read with two stall cycles
    begin
      int ren_cnt = 0, dlow = 0, ilow = 0;
      logic [31:0] got = 0;
      ram[32'h40] = 32'hDEADBEEF; gold[32'h40] = 32'hDEADBEEF;
      stall = 2; dREN = 1; daddr = 32'h40;
      for (int c = 0; c < 12; c++) begin
        settle();
        if (ramREN) ren_cnt++;
        if (!iwait) ilow++;
        if (!dwait) begin dlow++; got = dload; end
        tick();
        if (dlow != 0) dREN = 0;
      end
      chk("t1_ren_cycles", ren_cnt, 3);
      chk("t1_dwait_pulses", dlow, 1);
      chk("t1_dload", got, 32'hDEADBEEF);
      chk("t1_iwait_quiet", ilow, 0);
    end

    // T2: immediate write
    stall = 0; dWEN = 1; daddr = 32'h80; dstore = 32'h12345678;
    settle(); chk("t2_req_dwait", 32'(dwait), 1); tick();
    settle();
    chk("t2_ramWEN", {30'b0, ramREN, ramWEN}, 32'h1);
    chk("t2_ramaddr", ramaddr, 32'h80);
    chk("t2_ramstore", ramstore, 32'h12345678);
    chk("t2_dwait", 32'(dwait), 0);
    gold[32'h80] = 32'h12345678;
    tick();
    dWEN = 0;
    settle(); chk("t2_one_pulse", 32'(dwait), 1); chk("t2_ram", ram_rd(32'h80), 32'h12345678); tick();

    // T3: both continuously requesting
    begin
      logic [9:0] order = 0;
      int n = 0;
      iREN = 1; iaddr = 32'h300; dREN = 1; daddr = 32'h200;
      for (int c = 0; c < 100 && n < 10; c++) begin
        settle();
        if (!dwait) begin
          chk("t3_dload", dload, gold_rd(daddr));
          order = {order[8:0], 1'b0}; n++;
        end
        if (!iwait) begin
          chk("t3_iload", iload, gold_rd(32'h300));
          order = {order[8:0], 1'b1}; n++;
        end
        tick();
        if (n != 0 && order[0] == 1'b0) daddr = 32'h200 + 4 * $urandom_range(0, 7);
      end
      chk("t3_count", n, 10);
      chk("t3_order", 32'(order), 32'h021);
    end
    iREN = 0; dREN = 0;
    settle(); tick();

    // T4: two-word fill with icache pending
    begin
      logic [2:0] seq = 0;
      int cyc_at[3];
      int n = 0;
      dREN = 1; daddr = 32'h100; iREN = 1; iaddr = 32'h310;
      for (int c = 0; c < 30 && n < 3; c++) begin
        settle();
        if (!dwait) begin
          chk("t4_daddr", ramaddr, (n == 0) ? 32'h100 : 32'h104);
          chk("t4_dload", dload, gold_rd(ramaddr));
          seq = {seq[1:0], 1'b0}; cyc_at[n] = c; n++;
        end
        if (!iwait) begin
          chk("t4_iload", iload, gold_rd(32'h310));
          seq = {seq[1:0], 1'b1}; cyc_at[n] = c; n++;
        end
        tick();
        if (n == 1) daddr = 32'h104;
        if (n == 2) dREN = 0;
        if (n == 3) iREN = 0;
      end
      chk("t4_seq", 32'(seq), 32'h1);
      chk("t4_gap", cyc_at[1] - cyc_at[0], 2);
      chk("t4_first", cyc_at[0], 1);
    end
    iREN = 0; dREN = 0;

    // T5: abort a stalled read
    stall = 5; dREN = 1; daddr = 32'h140;
    settle(); tick();
    settle(); chk("t5_strobe", 32'(ramREN), 1); tick();
    dREN = 0;
    settle(); chk("t5_abort_ren", 32'(ramREN), 0); chk("t5_abort_dwait", 32'(dwait), 1); tick();
    stall = 0; dREN = 1; daddr = 32'h144;
    settle(); chk("t5_idle_ren", 32'(ramREN), 0); chk("t5_idle_dwait", 32'(dwait), 1); tick();
    settle(); chk("t5_retry_dwait", 32'(dwait), 0); chk("t5_retry_dload", dload, gold_rd(32'h144)); tick();
    dREN = 0;

    // T6: reset during an icache access
    stall = 5; iREN = 1; iaddr = 32'h320;
    settle(); tick();
    settle(); chk("t6_iacc", 32'(ramREN), 1); tick();
    RST = 1;
    settle(); chk("t6_rst_iwait", 32'(iwait), 1); tick();
    RST = 0; stall = 0;
    settle();
    chk("t6_post_ren", 32'(ramREN), 0);
    chk("t6_post_addr", ramaddr, 0);
    chk("t6_post_iwait", 32'(iwait), 1);
    tick();
    settle(); chk("t6_iwait", 32'(iwait), 0); chk("t6_iload", iload, gold_rd(32'h320)); tick();
    iREN = 0;
    settle(); tick();

    // Random phase
    rand_stall = 1; streak = 0; d_busy = 0; i_busy = 0; d_age = 0; i_age = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!d_busy) begin
        dREN = 0; dWEN = 0;
        if ($urandom_range(0, 2) == 0) begin
          d_busy = 1; d_age = 0; d_wr = 1'($urandom);
          daddr = 32'h200 + 4 * $urandom_range(0, 7);
          dstore = $urandom;
          dWEN = d_wr;
          dREN = d_wr ? 1'($urandom) : 1'b1;
        end
      end
      if (!i_busy) begin
        iREN = 0;
        if ($urandom_range(0, 2) == 0) begin
          i_busy = 1; i_age = 0; iREN = 1;
          iaddr = 32'h200 + 4 * $urandom_range(0, 7);
        end
      end
      settle();
      if (!iwait && !dwait) chk("r_both_low", 32'h0, 32'h1);
      if (!dwait) begin
        chk("r_dlat", 32'(d_age >= 1), 1);
        chk("r_daddr", ramaddr, daddr);
        chk("r_dload", dload, d_wr ? 32'h0 : gold_rd(daddr));
        chk("r_iload_idle", iload, 0);
        if (i_busy) begin
          chk("r_starve", 32'(streak < int'(SMAX)), 1);
          streak++;
        end
        if (d_wr) gold[daddr] = dstore;
        d_busy = 0;
      end
      if (!iwait) begin
        chk("r_ilat", 32'(i_age >= 1), 1);
        chk("r_iload", iload, gold_rd(iaddr));
        chk("r_dload_idle", dload, 0);
        streak = 0;
        i_busy = 0;
      end
      tick();
      if (d_busy) d_age++;
      if (i_busy) i_age++;
      if (d_age > 200) begin chk("r_d_timeout", 32'(d_age), 0); d_busy = 0; d_age = 0; end
      if (i_age > 200) begin chk("r_i_timeout", 32'(i_age), 0); i_busy = 0; i_age = 0; streak = 0; end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
